// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM states, response codes and address check.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // True when a word address falls inside a bank of nregs registers.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB SETUP/ACCESS sequencer with a programmable number of wait states.
// Produces the registered PREADY, the SETUP-accept strobe, the completion
// strobe and resp_load, which is high on the edge that raises PREADY.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic accept,
    output logic complete,
    output logic resp_load
);

    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("apb_wait_ctrl: WAIT_STATES must be in 0..15");
    end

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    apb_state_e state;
    logic [3:0] cnt;

    // A SETUP phase is accepted from IDLE, or back-to-back on the completing edge.
    assign accept    = psel && !penable && (state == IDLE || pready);
    assign complete  = pready;
    assign resp_load = (accept && NO_WAIT) ||
                       (state == ACCESS && !pready && psel && cnt == 4'd1);

    // FSM, wait counter and registered PREADY.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state  <= IDLE;
            cnt    <= '0;
            pready <= 1'b0;
        end else begin
            pready <= resp_load;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACCESS;
                        cnt   <= WS_LOAD;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        if (accept) cnt   <= WS_LOAD;
                        else        state <= IDLE;
                    end else if (!psel) begin
                        // Master abandoned the transfer: drop it silently.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_regbank.sv
// APB3 register bank: NREGS x DWIDTH registers, optional hardware-fed
// read-only slots, per-register write strobes and wait-state support.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int unsigned        DWIDTH      = 8,
    parameter int unsigned        NREGS       = 4,
    parameter int unsigned        AWIDTH      = 4,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [NREGS-1:0]   RO_MASK     = '0,
    parameter logic [DWIDTH-1:0]  RST_VAL     = '0
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [AWIDTH-1:0]        PADDR,
    input  logic [DWIDTH-1:0]        PWDATA,
    output logic [DWIDTH-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [NREGS*DWIDTH-1:0]  hw_in,
    output logic [NREGS*DWIDTH-1:0]  regs_out,
    output logic [NREGS-1:0]         wr_pulse
);

    if ((2 ** AWIDTH) < NREGS) begin : g_bad_awidth
        $error("apb_regbank: AWIDTH too narrow to address NREGS registers");
    end

    logic              accept, complete, resp_load;
    logic [AWIDTH-1:0] addr_q;
    logic              write_q, err_q;
    logic [AWIDTH-1:0] cur_addr;
    logic              cur_write, cur_err;
    logic              ro_paddr, dec_err;
    logic [DWIDTH-1:0] rd_val;
    logic [DWIDTH-1:0] regs_q [NREGS];

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .psel      (PSEL),
        .penable   (PENABLE),
        .pready    (PREADY),
        .accept    (accept),
        .complete  (complete),
        .resp_load (resp_load)
    );

    // Decode the incoming SETUP, and pick the live or captured transfer for the response.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ro_paddr = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (PADDR == AWIDTH'(i)) ro_paddr = RO_MASK[i];
        end
        dec_err   = (!addr_valid(32'(PADDR), NREGS) || (PWRITE && ro_paddr)) ? RESP_ERROR : RESP_OKAY;
        cur_addr  = accept ? PADDR   : addr_q;
        cur_write = accept ? PWRITE  : write_q;
        cur_err   = accept ? dec_err : err_q;
    end

    // Read mux: RO slots return live hardware values, others the stored register.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (cur_addr == AWIDTH'(i)) rd_val = RO_MASK[i] ? hw_in[i*DWIDTH +: DWIDTH] : regs_q[i];
        end
    end

    // Capture address, direction and error decision at SETUP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= RESP_OKAY;
        end else if (accept) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            err_q   <= dec_err;
        end
    end

    // Registered response, presented together with PREADY and cleared otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PSLVERR <= RESP_OKAY;
        end else begin
            PSLVERR <= resp_load ? cur_err : RESP_OKAY;
            PRDATA  <= (resp_load && cur_err == RESP_OKAY && !cur_write) ? rd_val : '0;
        end
    end

    // Commit a successful write on the completing edge and strobe its register.
    // NOTE: the bank is small control state whose contents software relies on
    // after reset, so it is reset explicitly rather than left to a RAM macro.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= RST_VAL;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (complete && write_q && err_q == RESP_OKAY) begin
                for (int i = 0; i < int'(NREGS); i++) begin
                    if (addr_q == AWIDTH'(i)) begin
                        regs_q[i]   <= PWDATA;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Flatten writable contents; read-only slots drive zero.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_out[i*DWIDTH +: DWIDTH] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_regbank.sv
// Scoreboard bench for apb_regbank: three instances with different wait-state
// and read-only configurations share one APB bus (separate PSEL per instance).
module tb_apb_regbank;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int ND = 3;

    typedef struct {
        int                d;
        logic              err;
        logic [DW-1:0]     rdata;
        int                waits;
        logic [NR-1:0]     pulse;
        logic [NR*DW-1:0]  regs;
    } exp_t;

    logic                     PCLK = 1'b0;
    logic                     PRESETn;
    logic [ND-1:0]            psel_v;
    logic                     PENABLE, PWRITE;
    logic [AW-1:0]            PADDR;
    logic [DW-1:0]            PWDATA;
    logic [NR*DW-1:0]         hw_in;
    logic [ND-1:0]            pready_v, pslverr_v;
    logic [ND-1:0][DW-1:0]    prdata_v;
    logic [ND-1:0][NR*DW-1:0] regs_out_v;
    logic [ND-1:0][NR-1:0]    wr_pulse_v;

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance register contents and configuration.
    logic [DW-1:0] mregs [ND][NR];
    logic [NR-1:0] ro_tab [ND];
    int            ws_tab [ND];
    exp_t          sbq [$];

    logic          mon_en = 1'b0;
    logic          in_access = 1'b0;
    int            act = 0;
    int            low_cnt = 0;
    logic          pend = 1'b0;
    int            pend_d = 0;
    logic [NR-1:0] pend_pulse = '0;
    logic [NR*DW-1:0] pend_regs = '0;

    always #5 PCLK = ~PCLK;

    apb_regbank #(.DWIDTH(DW), .NREGS(NR), .AWIDTH(AW), .WAIT_STATES(0),
                  .RO_MASK(4'b0001), .RST_VAL(8'h00)) u_ws0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_v[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[0]),
        .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]), .hw_in(hw_in),
        .regs_out(regs_out_v[0]), .wr_pulse(wr_pulse_v[0]));

    apb_regbank #(.DWIDTH(DW), .NREGS(NR), .AWIDTH(AW), .WAIT_STATES(3),
                  .RO_MASK(4'b0000), .RST_VAL(8'h00)) u_ws3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_v[1]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[1]),
        .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]), .hw_in(hw_in),
        .regs_out(regs_out_v[1]), .wr_pulse(wr_pulse_v[1]));

    apb_regbank #(.DWIDTH(DW), .NREGS(NR), .AWIDTH(AW), .WAIT_STATES(2),
                  .RO_MASK(4'b0000), .RST_VAL(8'h00)) u_ws2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_v[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[2]),
        .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2]), .hw_in(hw_in),
        .regs_out(regs_out_v[2]), .wr_pulse(wr_pulse_v[2]));

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack_regs(input int d);
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = ro_tab[d][i] ? 8'h00 : mregs[d][i];
        return v;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < NR; i++) mregs[d][i] = 8'h00;
    endtask

    // Issue one complete APB transfer; the expected outcome is queued at issue time.
    task automatic xfer(input int d, input bit wr, input int addr, input logic [DW-1:0] data);
        exp_t e;
        bit   bad, ro, done;
        bad     = (addr >= NR);
        ro      = !bad && ro_tab[d][addr];
        e.d     = d;
        e.waits = ws_tab[d];
        e.err   = bad || (wr && ro);
        e.pulse = '0;
        if (!e.err && wr) begin
            mregs[d][addr] = data;
            e.pulse[addr]  = 1'b1;
        end
        if (e.err || wr) e.rdata = 8'h00;
        else if (ro)     e.rdata = hw_in[addr*DW +: DW];
        else             e.rdata = mregs[d][addr];
        e.regs = pack_regs(d);
        sbq.push_back(e);

        act       = d;
        psel_v    = '0;
        psel_v[d] = 1'b1;
        PENABLE   = 1'b0;
        PWRITE    = wr;
        PADDR     = 4'(addr);
        PWDATA    = data;
        @(posedge PCLK); #1;
        PENABLE   = 1'b1;
        in_access = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge PCLK);
            if (pready_v[d]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no PREADY from instance %0d within 40 cycles", d);
            sbq.delete();
        end
        @(posedge PCLK); #1;
        psel_v    = '0;
        PENABLE   = 1'b0;
        in_access = 1'b0;
        PWDATA    = 8'($urandom);
    endtask

    // Monitor: response scoreboard, wait-state count, strobes and idle PRDATA.
    always @(negedge PCLK) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                logic [NR-1:0] exp_p;
                exp_p = (pend && pend_d == d) ? pend_pulse : '0;
                if (!pready_v[d]) check($sformatf("prdata_idle[%0d]", d), 64'(prdata_v[d]), 64'h0);
                check($sformatf("wr_pulse[%0d]", d), 64'(wr_pulse_v[d]), 64'(exp_p));
            end
            if (pend) begin
                check($sformatf("regs_out[%0d]", pend_d), 64'(regs_out_v[pend_d]), 64'(pend_regs));
                pend = 1'b0;
            end
            if (in_access) begin
                if (pready_v[act]) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_response", 64'h1, 64'h0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check($sformatf("wait_cycles[%0d]", e.d), 64'(low_cnt), 64'(e.waits));
                        check($sformatf("prdata[%0d]", e.d), 64'(prdata_v[e.d]), 64'(e.rdata));
                        check($sformatf("pslverr[%0d]", e.d), 64'(pslverr_v[e.d]), 64'(e.err));
                        pend       = 1'b1;
                        pend_d     = e.d;
                        pend_pulse = e.pulse;
                        pend_regs  = e.regs;
                    end
                    low_cnt = 0;
                end else begin
                    low_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ws_tab[0] = 0; ws_tab[1] = 3; ws_tab[2] = 2;
        ro_tab[0] = 4'b0001; ro_tab[1] = 4'b0000; ro_tab[2] = 4'b0000;
        clear_model();
        PRESETn = 1'b0;
        psel_v  = '0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        hw_in   = {8'h11, 8'h22, 8'h33, 8'h3C};
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        mon_en = 1'b1;

        // Reset state of every instance.
        @(negedge PCLK);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_pready[%0d]", d), 64'(pready_v[d]), 64'h0);
            check($sformatf("reset_pslverr[%0d]", d), 64'(pslverr_v[d]), 64'h0);
            check($sformatf("reset_regs_out[%0d]", d), 64'(regs_out_v[d]), 64'h0);
        end
        @(posedge PCLK); #1;
        for (int a = 0; a < NR; a++) xfer(1, 0, a, 8'h00);

        // Zero-wait write then read.
        xfer(0, 1, 2, 8'hA5);
        xfer(0, 0, 2, 8'h00);

        // Three wait states.
        xfer(1, 1, 1, 8'h5A);
        xfer(1, 0, 1, 8'h00);

        // Read-only register fed by hardware.
        xfer(0, 0, 0, 8'h00);
        xfer(0, 1, 0, 8'hFF);
        xfer(0, 0, 0, 8'h00);

        // Out-of-range address.
        xfer(0, 0, 5, 8'h00);
        xfer(0, 1, 5, 8'hC3);
        xfer(1, 1, 5, 8'hC3);
        xfer(1, 0, 1, 8'h00);

        // Master drops PSEL mid-ACCESS: nothing may be committed or completed.
        act = 1;
        psel_v = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd3; PWDATA = 8'hEE;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_pready", 64'(pready_v[1]), 64'h0);
        @(posedge PCLK); #1 psel_v = '0; PENABLE = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            check("abort_no_pready", 64'(pready_v[1]), 64'h0);
        end
        @(posedge PCLK); #1;
        xfer(1, 0, 3, 8'h00);

        // Randomised traffic across all instances.
        for (int k = 0; k < 60; k++) begin
            if (k % 8 == 0) hw_in = {$urandom};
            xfer($urandom_range(0, ND - 1), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7), 8'($urandom));
        end

        // Reset during the ACCESS phase of a write with two wait states.
        act = 2;
        psel_v = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1; PWDATA = 8'h77;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        clear_model();
        #1;
        check("midreset_pready", 64'(pready_v[2]), 64'h0);
        check("midreset_regs_out", 64'(regs_out_v[2]), 64'h0);
        @(posedge PCLK); #1 psel_v = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("postreset_regs_out", 64'(regs_out_v[2]), 64'h0);
        @(posedge PCLK); #1;
        xfer(2, 0, 1, 8'h00);
        xfer(2, 1, 1, 8'h77);
        xfer(2, 0, 1, 8'h00);
        xfer(0, 0, 2, 8'h00);

        repeat (3) @(posedge PCLK);
        check("scoreboard_drained", 64'(sbq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regbank.md
Name: apb_regbank

Overview:
- Parametrised APB3 slave register bank: NREGS registers of DWIDTH bits each, word-indexed by PADDR.
- Fully synchronous to PCLK, with a proper SETUP/ACCESS state machine and a programmable number of wait states.
- Responds with PREADY and PSLVERR; supports read-only status registers fed by hardware and per-register write strobes.
- Sits between the APB interconnect and peripheral control logic, replacing single-register slaves.

Parameters:
- DWIDTH, 8: data width of PWDATA, PRDATA and each register.
- NREGS, 4: number of registers; valid addresses are 0..NREGS-1.
- AWIDTH, 4: PADDR width; must satisfy 2**AWIDTH >= NREGS.
- WAIT_STATES, 0: number of ACCESS cycles with PREADY low before completion (0..15).
- RO_MASK, 0: NREGS-bit mask; bit i=1 makes register i read-only, with its read value taken from hw_in.
- RST_VAL, 0: reset value applied to every writable register.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  AWIDTH  word address.
- PWDATA  in  DWIDTH  write data.
- PRDATA  out  DWIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- hw_in  in  NREGS*DWIDTH  hardware values for read-only registers; register i occupies bits [i*DWIDTH +: DWIDTH].
- regs_out  out  NREGS*DWIDTH  current writable register contents; RO slots drive 0.
- wr_pulse  out  NREGS  one-cycle strobe per register, asserted the cycle after a successful write.

Behaviour:
- Reset (asynchronous, PRESETn=0):
  - FSM to IDLE.
  - Writable registers to RST_VAL.
  - PRDATA=0, PREADY=0, PSLVERR=0, wr_pulse=0, wait counter=0.
  - Applies mid-transfer: any in-flight write is discarded.
- FSM states IDLE, ACCESS:
  - IDLE: PREADY=0. On PSEL=1 and PENABLE=0 (SETUP seen at a PCLK edge), go to ACCESS. Also capture PADDR and PWRITE, load the wait counter with WAIT_STATES, and decode the error condition.
  - ACCESS with counter>0: decrement the counter; PREADY stays 0.
  - ACCESS with counter==0: PREADY=1 for exactly one cycle; PRDATA and PSLVERR are driven in that same cycle. All three outputs are registered, and are set on the edge that makes the counter reach 0, or on the SETUP edge when WAIT_STATES=0.
  - The edge ending the PREADY=1 cycle completes the transfer:
    - a valid write commits PWDATA;
    - the FSM returns to IDLE, or a back-to-back SETUP is accepted on the same edge if PSEL=1 and PENABLE=0.
- Latency: each transfer takes 1 SETUP cycle plus WAIT_STATES+1 ACCESS cycles.
- Error (PSLVERR=1 with PREADY) is raised for:
  - a captured address >= NREGS;
  - a write to a register whose RO_MASK bit is set.
  - On error, the write has no effect, wr_pulse stays 0, and PRDATA=0.
- Read data:
  - writable register i returns its stored value;
  - RO register i returns hw_in[i], sampled on the edge that raises PREADY.
- PRDATA=0 whenever PREADY=0 or the transfer is a write.
- Writes take effect at completion only: regs_out updates on the completing edge, and wr_pulse[i] is high for the following cycle.
- Protocol violation (PSEL drops during ACCESS before completion): return to IDLE, with no commit, no PREADY and no wr_pulse.
- PADDR and PWDATA changes during ACCESS are ignored for decode; the address is captured at SETUP. PWDATA is sampled at completion.
- Wait counter width is 4 bits; WAIT_STATES>15 is illegal and is rejected by an elaboration-time check.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state enum (IDLE, ACCESS);
  - APB response constants (OKAY=0, ERROR=1);
  - helper function addr_valid(addr, nregs).
- One natural sub-module, apb_wait_ctrl, holds the FSM plus wait counter and produces PREADY and the complete strobe. The register array and read mux stay in the top level.

Test Plan:
- Reset then idle: after PRESETn deasserts, all registers read 0x00, PREADY=0 and regs_out=0.
- WAIT_STATES=0, write 0xA5 to addr 2 then read addr 2:
  - PREADY high on the first ACCESS cycle;
  - PRDATA=0xA5 and PSLVERR=0;
  - wr_pulse[2] high for 1 cycle after the write;
  - regs_out slot 2 = 0xA5.
- WAIT_STATES=3, read addr 1: exactly 3 ACCESS cycles with PREADY=0, then 1 cycle with PREADY=1 and PRDATA = stored value.
- RO_MASK=4'b0001, hw_in slot 0 = 0x3C:
  - read addr 0 returns 0x3C;
  - write 0xFF to addr 0 gives PSLVERR=1 and no wr_pulse;
  - a subsequent read still returns 0x3C.
- Read and write at addr 5 with NREGS=4: PSLVERR=1 with PREADY, PRDATA=0, and no register changes.
- Reset mid-operation: assert PRESETn=0 during ACCESS of a write of 0x77 with WAIT_STATES=2. Required result: register stays RST_VAL, FSM returns to IDLE, and PREADY=0 immediately.
